// File: rtl/x_500_qr_recon_241.sv
// Digit-serial reverse converter for the mod-241 datapath.
// Rebuilds X = Q*241 + R one 8-bit digit of Q per clock.
module x_500_qr_recon_241 #(
  parameter int XW = 500,
  parameter int QW = 493,
  parameter int M  = 241,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [QW-1:0] Q,
  input  logic [7:0]    R,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] X,
  output logic          err_rng,
  output logic          err_ovf
);

  localparam int NDIG = (XW + DW - 1) / DW;
  localparam int SW   = NDIG * DW;
  localparam int CW   = $clog2(NDIG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [SW-1:0] q_sh;
  logic [SW-1:0] x_sh;
  logic [7:0]    carry;
  logic [CW-1:0] cnt;
  logic [15:0]   q16;
  logic [15:0]   p;
  logic          last;
  logic          accept;
  logic          release_x;

  // One digit step: q*241 as (q<<8)-(q<<4)+q, plus incoming carry.
  always_comb begin
    q16 = {8'b0, q_sh[7:0]};
    p   = (q16 << 8) - (q16 << 4) + q16 + {8'b0, carry};
  end

  assign last      = (cnt == CW'(NDIG - 1));
  assign in_ready  = (state == S_IDLE);
  assign accept    = in_valid && (state == S_IDLE);
  assign release_x = out_valid && out_ready;

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (in_valid) state_nx = S_RUN;
      S_RUN:  if (last) state_nx = S_DONE;
      S_DONE: if (release_x) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Shift/accumulate datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_sh      <= '0;
      x_sh      <= '0;
      carry     <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      X         <= '0;
      err_rng   <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            q_sh    <= {{(SW-QW){1'b0}}, Q};
            carry   <= R;
            cnt     <= '0;
            err_rng <= (R >= 8'(M));
          end
        end
        S_RUN: begin
          x_sh  <= {p[7:0], x_sh[SW-1:8]};
          carry <= p[15:8];
          q_sh  <= q_sh >> 8;
          cnt   <= cnt + CW'(1);
        end
        S_DONE: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            X         <= x_sh[XW-1:0];
            err_ovf   <= (|x_sh[SW-1:XW]) | (|carry);
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_x_500_qr_recon_241.sv
// Directed bench for the mod-241 reverse converter.
// Expected X comes from a wide-arithmetic reference Q*241+R.
module tb_x_500_qr_recon_241;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [492:0] Q = '0;
  logic [7:0]   R = '0;
  logic         in_ready;
  logic         out_valid;
  logic [499:0] X;
  logic         err_rng;
  logic         err_ovf;

  int checks = 0;
  int failures = 0;

  x_500_qr_recon_241 dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .Q(Q),
    .R(R),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .X(X),
    .err_rng(err_rng),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [499:0] obs,
                     input logic [499:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag,
                        input logic [492:0] q,
                        input logic [7:0] r,
                        input int hold,
                        input bit poke);
    logic [503:0] full;
    logic [499:0] xs;
    int k;
    full = 504'(q) * 504'd241 + 504'(r);
    @(negedge clk);
    chk({tag, ".in_ready"}, 500'(in_ready), 500'(1));
    in_valid = 1'b1;
    Q = q;
    R = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Q = '0;
    R = '0;
    k = 0;
    while (!out_valid && k < 80) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({tag, ".latency"}, 500'(k), 500'(64));
    chk({tag, ".X"}, X, full[499:0]);
    chk({tag, ".err_rng"}, 500'(err_rng), 500'(r >= 8'd241));
    chk({tag, ".err_ovf"}, 500'(err_ovf), 500'(|full[503:500]));
    xs = X;
    if (poke) begin
      in_valid = 1'b1;
      Q = ~q;
      R = r + 8'd1;
    end
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, ".hold_ov"}, 500'(out_valid), 500'(1));
      chk({tag, ".hold_X"}, X, xs);
      chk({tag, ".hold_rdy"}, 500'(in_ready), 500'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, ".post_ov"}, 500'(out_valid), 500'(0));
    chk({tag, ".post_rdy"}, 500'(in_ready), 500'(1));
    chk({tag, ".post_X"}, X, xs);
  endtask

  initial begin
    logic [503:0] allones;
    logic [503:0] qmax;
    logic [503:0] rmax;
    logic [503:0] qfull;
    logic [511:0] tmp;
    logic [492:0] qr;
    int seen;

    repeat (3) @(posedge clk);
    #1;
    chk("rst.out_valid", 500'(out_valid), 500'(0));
    chk("rst.X", X, 500'(0));
    chk("rst.err_rng", 500'(err_rng), 500'(0));
    chk("rst.err_ovf", 500'(err_ovf), 500'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready", 500'(in_ready), 500'(1));

    run_op("q0r5", 493'(0), 8'd5, 0, 1'b0);
    chk("q0r5.const", X, 500'd5);

    run_op("q1r0", 493'(1), 8'd0, 0, 1'b0);
    chk("q1r0.const", X, 500'd241);

    run_op("q256r240", 493'(256), 8'd240, 0, 1'b0);
    chk("q256r240.const", X, 500'd61936);

    allones = {4'b0, {500{1'b1}}};
    qmax = allones / 504'd241;
    rmax = allones % 504'd241;
    run_op("max", qmax[492:0], rmax[7:0], 0, 1'b0);
    chk("max.const", X, {500{1'b1}});
    chk("max.ovf", 500'(err_ovf), 500'(0));

    qfull = {11'b0, {493{1'b1}}};
    run_op("qall", qfull[492:0], 8'd0, 0, 1'b0);
    chk("qall.ovf", 500'(err_ovf), 500'(1));

    run_op("rng", 493'(0), 8'd241, 0, 1'b0);
    chk("rng.const", X, 500'd241);
    chk("rng.flag", 500'(err_rng), 500'(1));

    run_op("bp", 493'(123456789), 8'd17, 10, 1'b1);

    @(negedge clk);
    in_valid = 1'b1;
    Q = 493'(12345);
    R = 8'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort.ov", 500'(out_valid), 500'(0));
    chk("abort.X", X, 500'(0));
    chk("abort.err_rng", 500'(err_rng), 500'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort.in_ready", 500'(in_ready), 500'(1));
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("abort.no_out", 500'(seen), 500'(0));

    run_op("q7r3", 493'(7), 8'd3, 0, 1'b0);
    chk("q7r3.const", X, 500'd1690);

    for (int n = 0; n < 200; n++) begin
      for (int j = 0; j < 16; j++) tmp[j*32 +: 32] = $urandom;
      qr = tmp[492:0] >> $urandom_range(0, 492);
      run_op("rand", qr, 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
